// File: rtl/vproc_vcfg_unit.sv
// -----------------------------------------------------------------------------
// vproc_vcfg_unit
//
// Vector configuration unit. Executes decoded vsetvl/vsetvli/vsetivli
// instructions. It computes the new vl/vtype according to RVV 1.0, holds the
// architectural vtype/vl state used by the other units, and returns the new vl
// to the scalar core through a single-entry result buffer.
//
// Ports:
//   clk_i        clock, rising edge
//   sync_rst_ni  synchronous active-low reset
//   cfg_valid_i  decoded configuration instruction valid
//   cfg_ready_o  unit can accept (!res_valid_o || res_ready_i)
//   cfg_mode_i   decoded vsew/lmul/agnostic/vlmax/keep_vl fields
//   cfg_avl_i    application vector length (rs1 value or uimm)
//   res_valid_o  new vl available for the rd writeback
//   res_ready_i  scalar core takes the result
//   res_vl_o     zero-extended new vl (0 when vill)
//   vsew_o, lmul_o, agnostic_o, vill_o, vl_o, vl_0_o : current vtype/vl state
// -----------------------------------------------------------------------------

package vproc_vcfg_pkg;

  typedef enum logic [1:0] {
    VSEW_8       = 2'b00,
    VSEW_16      = 2'b01,
    VSEW_32      = 2'b10,
    VSEW_INVALID = 2'b11
  } cfg_vsew;

  // The encoding is the signed log2 of LMUL; 3'b100 has no meaning.
  typedef enum logic [2:0] {
    LMUL_1       = 3'b000,
    LMUL_2       = 3'b001,
    LMUL_4       = 3'b010,
    LMUL_8       = 3'b011,
    LMUL_INVALID = 3'b100,
    LMUL_F8      = 3'b101,
    LMUL_F4      = 3'b110,
    LMUL_F2      = 3'b111
  } cfg_lmul;

  typedef struct packed {
    cfg_vsew    vsew;
    cfg_lmul    lmul;
    logic [1:0] agnostic;  // {vma, vta}
    logic       vlmax;     // rs1 == x0 with rd != x0: request VLMAX
    logic       keep_vl;   // rs1 == x0 and rd == x0: keep the current vl
  } op_mode_cfg;

endpackage


module vproc_vcfg_unit
  import vproc_vcfg_pkg::*;
#(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned VL_W   = $clog2(VREG_W) + 1
) (
  input  logic            clk_i,
  input  logic            sync_rst_ni,

  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  op_mode_cfg      cfg_mode_i,
  input  logic [31:0]     cfg_avl_i,

  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [31:0]     res_vl_o,

  output cfg_vsew         vsew_o,
  output cfg_lmul         lmul_o,
  output logic [1:0]      agnostic_o,
  output logic            vill_o,
  output logic [VL_W-1:0] vl_o,
  output logic            vl_0_o
);

  localparam int LOG2_VREG_W = $clog2(VREG_W);

  // Architectural state and result buffer.
  cfg_vsew         vsew_q;
  cfg_lmul         lmul_q;
  logic [1:0]      agnostic_q;
  logic            vill_q;
  logic [VL_W-1:0] vl_q;
  logic            res_valid_q;
  logic [31:0]     res_vl_q;

  logic accept;

  // Ready depends only on the buffer state so that there is no combinational
  // path from cfg_valid_i back to cfg_ready_o.
  assign cfg_ready_o = !res_valid_q || res_ready_i;
  assign accept      = cfg_valid_i && cfg_ready_o;

  // New configuration computation.
  logic signed [2:0] lmul_s;
  logic signed [2:0] cur_lmul_s;
  int                vlmax_log2;
  int                new_ratio;
  int                cur_ratio;
  logic [31:0]       vlmax_val;
  logic              cfg_illegal;
  logic              new_vill;
  logic [31:0]       new_vl;

  // NOTE: every variable written in this block gets a default on entry so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    lmul_s      = $signed(cfg_mode_i.lmul);
    cur_lmul_s  = $signed(lmul_q);
    cfg_illegal = 1'b0;
    new_vill    = 1'b0;
    new_vl      = 32'd0;

    // log2(VLMAX) = log2(VREG_W / 8) - vsew + lmul. Only meaningful for legal
    // configurations, where it is never negative.
    vlmax_log2 = LOG2_VREG_W - 3 - int'(cfg_mode_i.vsew) + int'(lmul_s);
    vlmax_val  = 32'd1 << vlmax_log2;

    // SEW/LMUL ratio in log2 form; keep_vl is only legal if it is unchanged.
    new_ratio = int'(cfg_mode_i.vsew) - int'(lmul_s);
    cur_ratio = int'(vsew_q) - int'(cur_lmul_s);

    // ELEN is 32: fractional LMUL must still leave room for one SEW element.
    if (cfg_mode_i.vsew == VSEW_INVALID) cfg_illegal = 1'b1;
    case (cfg_mode_i.lmul)
      LMUL_INVALID: cfg_illegal = 1'b1;
      LMUL_F8:      cfg_illegal = 1'b1;
      LMUL_F4:      if (cfg_mode_i.vsew != VSEW_8)  cfg_illegal = 1'b1;
      LMUL_F2:      if (cfg_mode_i.vsew == VSEW_32) cfg_illegal = 1'b1;
      default:      ;
    endcase

    if (cfg_illegal) begin
      new_vill = 1'b1;
    end else if (cfg_mode_i.keep_vl) begin
      if (vill_q || (new_ratio != cur_ratio)) begin
        new_vill = 1'b1;
      end else begin
        new_vl = 32'(vl_q);
      end
    end else if (cfg_mode_i.vlmax) begin
      new_vl = vlmax_val;
    end else begin
      new_vl = (cfg_avl_i < vlmax_val) ? cfg_avl_i : vlmax_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      vsew_q      <= VSEW_8;
      lmul_q      <= LMUL_1;
      agnostic_q  <= 2'b00;
      vill_q      <= 1'b1;
      vl_q        <= '0;
      res_valid_q <= 1'b0;
      res_vl_q    <= 32'd0;
    end else if (accept) begin
      // Accept and drain may coincide: the buffer simply reloads.
      res_valid_q <= 1'b1;
      res_vl_q    <= new_vl;
      vill_q      <= new_vill;
      vl_q        <= new_vl[VL_W-1:0];
      if (new_vill) begin
        vsew_q     <= VSEW_8;
        lmul_q     <= LMUL_1;
        agnostic_q <= 2'b00;
      end else begin
        vsew_q     <= cfg_mode_i.vsew;
        lmul_q     <= cfg_mode_i.lmul;
        agnostic_q <= cfg_mode_i.agnostic;
      end
    end else if (res_ready_i) begin
      // Drain without accept: res_vl keeps its last value.
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_vl_o    = res_vl_q;
  assign vsew_o      = vsew_q;
  assign lmul_o      = lmul_q;
  assign agnostic_o  = agnostic_q;
  assign vill_o      = vill_q;
  assign vl_o        = vl_q;
  assign vl_0_o      = (vl_q == '0);

endmodule

// File: tb/tb_vproc_vcfg_unit.sv
// -----------------------------------------------------------------------------
// tb_vproc_vcfg_unit
//
// Directed self-checking bench for vproc_vcfg_unit with VREG_W = 128.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_vproc_vcfg_unit;
  import vproc_vcfg_pkg::*;

  localparam int unsigned VREG_W = 128;
  localparam int unsigned VL_W   = $clog2(VREG_W) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_valid;
  logic            cfg_ready;
  op_mode_cfg      cfg_mode;
  logic [31:0]     cfg_avl;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_vl;
  cfg_vsew         vsew;
  cfg_lmul         lmul;
  logic [1:0]      agnostic;
  logic            vill;
  logic [VL_W-1:0] vl;
  logic            vl_0;

  int tests = 0;
  int fails = 0;
  int handshakes = 0;

  always #5 clk = ~clk;

  vproc_vcfg_unit #(.VREG_W(VREG_W), .VL_W(VL_W)) dut (
    .clk_i       (clk),
    .sync_rst_ni (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_mode_i  (cfg_mode),
    .cfg_avl_i   (cfg_avl),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_vl_o    (res_vl),
    .vsew_o      (vsew),
    .lmul_o      (lmul),
    .agnostic_o  (agnostic),
    .vill_o      (vill),
    .vl_o        (vl),
    .vl_0_o      (vl_0)
  );

  // Counts results taken by the scalar core.
  always @(posedge clk) begin
    if (rst_n && res_valid && res_ready) handshakes++;
  end

  task automatic set_cfg(input cfg_vsew sew, input cfg_lmul lm, input logic [1:0] agn,
                         input logic vmax, input logic keep, input logic [31:0] avl);
    cfg_mode.vsew     = sew;
    cfg_mode.lmul     = lm;
    cfg_mode.agnostic = agn;
    cfg_mode.vlmax    = vmax;
    cfg_mode.keep_vl  = keep;
    cfg_avl           = avl;
  endtask

  // Presents one instruction for exactly one edge (caller ensures ready).
  task automatic issue(input cfg_vsew sew, input cfg_lmul lm, input logic [1:0] agn,
                       input logic vmax, input logic keep, input logic [31:0] avl);
    set_cfg(sew, lm, agn, vmax, keep, avl);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (vill !== 1'b1) begin fails++; $display("FAIL reset_vill: got %0b exp 1", vill); end
    tests++; if (vsew !== VSEW_8) begin fails++; $display("FAIL reset_vsew: got %0d exp 0", vsew); end
    tests++; if (lmul !== LMUL_1) begin fails++; $display("FAIL reset_lmul: got %0d exp 0", lmul); end
    tests++; if (agnostic !== 2'b00) begin fails++; $display("FAIL reset_agnostic: got %0d exp 0", agnostic); end
    tests++; if (vl !== '0) begin fails++; $display("FAIL reset_vl: got %0d exp 0", vl); end
    tests++; if (vl_0 !== 1'b1) begin fails++; $display("FAIL reset_vl_0: got %0b exp 1", vl_0); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %0b exp 0", res_valid); end
    tests++; if (res_vl !== 32'd0) begin fails++; $display("FAIL reset_res_vl: got %0d exp 0", res_vl); end
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready: got %0b exp 1", cfg_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    issue(VSEW_8, LMUL_1, 2'b11, 1'b0, 1'b0, 32'd100);
    tests++; if (vl !== 8'd16) begin fails++; $display("FAIL basic_vl: got %0d exp 16", vl); end
    tests++; if (res_vl !== 32'd16) begin fails++; $display("FAIL basic_res_vl: got %0d exp 16", res_vl); end
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL basic_res_valid: got %0b exp 1", res_valid); end
    tests++; if (vill !== 1'b0) begin fails++; $display("FAIL basic_vill: got %0b exp 0", vill); end
    tests++; if (agnostic !== 2'b11) begin fails++; $display("FAIL basic_agnostic: got %0d exp 3", agnostic); end
    tests++; if (vl_0 !== 1'b0) begin fails++; $display("FAIL basic_vl_0: got %0b exp 0", vl_0); end
  endtask

  task automatic test_avl();
    issue(VSEW_32, LMUL_8, 2'b00, 1'b0, 1'b0, 32'd20);
    tests++; if (vl !== 8'd20) begin fails++; $display("FAIL avl_below_max: got %0d exp 20", vl); end
    tests++; if (vsew !== VSEW_32 || lmul !== LMUL_8) begin fails++; $display("FAIL avl_vtype: got sew %0d lmul %0d exp 2 3", vsew, lmul); end
    issue(VSEW_32, LMUL_8, 2'b00, 1'b0, 1'b0, 32'd40);
    tests++; if (vl !== 8'd32) begin fails++; $display("FAIL avl_clamped: got %0d exp 32", vl); end
    // Large avl must be compared at full 32-bit width.
    issue(VSEW_8, LMUL_8, 2'b00, 1'b0, 1'b0, 32'h0001_0005);
    tests++; if (vl !== 8'd128) begin fails++; $display("FAIL avl_wide: got %0d exp 128", vl); end
    issue(VSEW_16, LMUL_2, 2'b01, 1'b1, 1'b0, 32'd0);
    tests++; if (vl !== 8'd16) begin fails++; $display("FAIL vlmax_req: got %0d exp 16", vl); end
    tests++; if (res_vl !== 32'd16) begin fails++; $display("FAIL vlmax_res_vl: got %0d exp 16", res_vl); end
    issue(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0, 32'd0);
    tests++; if (vl !== 8'd0 || vl_0 !== 1'b1 || vill !== 1'b0) begin fails++; $display("FAIL avl_zero: got vl %0d vl_0 %0b vill %0b exp 0 1 0", vl, vl_0, vill); end
  endtask

  task automatic test_illegal();
    issue(VSEW_8, LMUL_F8, 2'b11, 1'b0, 1'b0, 32'd10);
    tests++; if (vill !== 1'b1 || vl !== '0 || res_vl !== 32'd0) begin fails++; $display("FAIL ill_f8: got vill %0b vl %0d res_vl %0d exp 1 0 0", vill, vl, res_vl); end
    tests++; if (lmul !== LMUL_1 || vsew !== VSEW_8 || agnostic !== 2'b00) begin fails++; $display("FAIL ill_f8_vtype: got lmul %0d sew %0d agn %0d exp 0 0 0", lmul, vsew, agnostic); end
    issue(VSEW_16, LMUL_F4, 2'b00, 1'b0, 1'b0, 32'd10);
    tests++; if (vill !== 1'b1) begin fails++; $display("FAIL ill_f4_sew16: got %0b exp 1", vill); end
    issue(VSEW_8, LMUL_F4, 2'b00, 1'b0, 1'b0, 32'd9);
    tests++; if (vill !== 1'b0 || vl !== 8'd4) begin fails++; $display("FAIL f4_sew8: got vill %0b vl %0d exp 0 4", vill, vl); end
    issue(VSEW_32, LMUL_F2, 2'b00, 1'b0, 1'b0, 32'd9);
    tests++; if (vill !== 1'b1) begin fails++; $display("FAIL ill_f2_sew32: got %0b exp 1", vill); end
    issue(VSEW_16, LMUL_F2, 2'b00, 1'b0, 1'b0, 32'd9);
    tests++; if (vill !== 1'b0 || vl !== 8'd4) begin fails++; $display("FAIL f2_sew16: got vill %0b vl %0d exp 0 4", vill, vl); end
    issue(VSEW_INVALID, LMUL_1, 2'b00, 1'b0, 1'b0, 32'd9);
    tests++; if (vill !== 1'b1) begin fails++; $display("FAIL ill_sew_inv: got %0b exp 1", vill); end
    issue(VSEW_8, LMUL_INVALID, 2'b00, 1'b1, 1'b0, 32'd9);
    tests++; if (vill !== 1'b1 || res_vl !== 32'd0) begin fails++; $display("FAIL ill_lmul_inv: got vill %0b res_vl %0d exp 1 0", vill, res_vl); end
  endtask

  task automatic test_keep_vl();
    issue(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0, 32'd5);
    tests++; if (vl !== 8'd5) begin fails++; $display("FAIL keep_setup: got %0d exp 5", vl); end
    issue(VSEW_16, LMUL_2, 2'b10, 1'b0, 1'b1, 32'd99);
    tests++; if (vill !== 1'b0 || vl !== 8'd5 || res_vl !== 32'd5) begin fails++; $display("FAIL keep_same_ratio: got vill %0b vl %0d res_vl %0d exp 0 5 5", vill, vl, res_vl); end
    tests++; if (vsew !== VSEW_16 || lmul !== LMUL_2) begin fails++; $display("FAIL keep_vtype: got sew %0d lmul %0d exp 1 1", vsew, lmul); end
    issue(VSEW_16, LMUL_1, 2'b00, 1'b0, 1'b1, 32'd99);
    tests++; if (vill !== 1'b1 || vl !== '0) begin fails++; $display("FAIL keep_ratio_change: got vill %0b vl %0d exp 1 0", vill, vl); end
    // Reset-style vtype (SEW8/LMUL1) with vill set must not allow keep_vl.
    issue(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b1, 32'd99);
    tests++; if (vill !== 1'b1) begin fails++; $display("FAIL keep_from_vill: got %0b exp 1", vill); end
  endtask

  task automatic test_back_to_back();
    int hs_base;
    res_ready = 1'b1;
    issue(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0, 32'd7);
    hs_base = handshakes;
    res_ready = 1'b0;
    set_cfg(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0, 32'd3);
    cfg_valid = 1'b1;
    #1;
    tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL bp_ready: got %0b exp 0", cfg_ready); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (vl !== 8'd7 || res_vl !== 32'd7 || res_valid !== 1'b1) begin fails++; $display("FAIL bp_frozen: got vl %0d res_vl %0d res_valid %0b exp 7 7 1", vl, res_vl, res_valid); end
    tests++; if (handshakes != hs_base) begin fails++; $display("FAIL bp_no_drain: got %0d exp %0d", handshakes, hs_base); end
    res_ready = 1'b1;
    #1;
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b exp 1", cfg_ready); end
    @(posedge clk); #1;
    tests++; if (vl !== 8'd3 || res_vl !== 32'd3 || res_valid !== 1'b1) begin fails++; $display("FAIL bp_accept: got vl %0d res_vl %0d res_valid %0b exp 3 3 1", vl, res_vl, res_valid); end
    for (int i = 1; i <= 4; i++) begin
      cfg_avl = 32'(i);
      #1;
      tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_%0d: got %0b exp 1", i, cfg_ready); end
      @(posedge clk); #1;
      tests++; if (res_vl !== 32'(i) || res_valid !== 1'b1) begin fails++; $display("FAIL b2b_res_%0d: got %0d valid %0b exp %0d 1", i, res_vl, res_valid, i); end
    end
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (res_valid !== 1'b0 || res_vl !== 32'd4) begin fails++; $display("FAIL drain: got valid %0b res_vl %0d exp 0 4", res_valid, res_vl); end
    tests++; if (handshakes != hs_base + 6) begin fails++; $display("FAIL result_count: got %0d exp %0d", handshakes - hs_base, 6); end
  endtask

  task automatic test_reset_pending();
    res_ready = 1'b1;
    issue(VSEW_16, LMUL_4, 2'b11, 1'b0, 1'b0, 32'd9);
    res_ready = 1'b0;
    tests++; if (res_valid !== 1'b1 || vl !== 8'd9) begin fails++; $display("FAIL rstp_setup: got valid %0b vl %0d exp 1 9", res_valid, vl); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests++; if (res_valid !== 1'b0 || vill !== 1'b1 || vl !== '0 || res_vl !== 32'd0) begin fails++; $display("FAIL rstp_cleared: got valid %0b vill %0b vl %0d res_vl %0d exp 0 1 0 0", res_valid, vill, vl, res_vl); end
    rst_n = 1'b1;
    res_ready = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    res_ready = 1'b1;
    cfg_mode  = '0;
    cfg_avl   = 32'd0;
    test_reset();
    test_basic();
    test_avl();
    test_illegal();
    test_keep_vl();
    test_back_to_back();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
